// File: rtl/axi_wr_arbiter.sv
// AXI write-channel arbiter: NM masters onto one slave.
// Round-robin AW grant held through the W burst; B routed by ID.
module axi_wr_arbiter #(
    parameter int  M_WIDTH = 2,
    localparam int NM      = 1 << M_WIDTH
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic [NM*2-1:0]       M_WR_ADDR_ID,
    input  logic [NM*32-1:0]      M_WR_ADDR,
    input  logic [NM*8-1:0]       M_WR_ADDR_LEN,
    input  logic [NM*2-1:0]       M_WR_ADDR_BURST,
    input  logic [NM-1:0]         M_WR_ADDR_VALID,
    output logic [NM-1:0]         M_WR_ADDR_READY,
    input  logic [NM*32-1:0]      M_WR_DATA,
    input  logic [NM*4-1:0]       M_WR_STRB,
    input  logic [NM-1:0]         M_WR_DATA_LAST,
    input  logic [NM-1:0]         M_WR_DATA_VALID,
    output logic [NM-1:0]         M_WR_DATA_READY,
    output logic [NM*2-1:0]       M_WR_BACK_ID,
    output logic [NM*2-1:0]       M_WR_BACK_RESP,
    output logic [NM-1:0]         M_WR_BACK_VALID,
    input  logic [NM-1:0]         M_WR_BACK_READY,
    output logic [M_WIDTH+1:0]    S_WR_ADDR_ID,
    output logic [31:0]           S_WR_ADDR,
    output logic [7:0]            S_WR_ADDR_LEN,
    output logic [1:0]            S_WR_ADDR_BURST,
    output logic                  S_WR_ADDR_VALID,
    input  logic                  S_WR_ADDR_READY,
    output logic [31:0]           S_WR_DATA,
    output logic [3:0]            S_WR_STRB,
    output logic                  S_WR_DATA_LAST,
    output logic                  S_WR_DATA_VALID,
    input  logic                  S_WR_DATA_READY,
    input  logic [M_WIDTH+1:0]    S_WR_BACK_ID,
    input  logic [1:0]            S_WR_BACK_RESP,
    input  logic                  S_WR_BACK_VALID,
    output logic                  S_WR_BACK_READY,
    output logic [M_WIDTH-1:0]    GRANT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [M_WIDTH-1:0]  ptr_q, ptr_d;
    logic [M_WIDTH-1:0]  grant_q, grant_d;
    logic [M_WIDTH-1:0]  pick;
    logic [M_WIDTH-1:0]  bk;

    // Round-robin pick: descending scan so the nearest requester after ptr wins
    always_comb begin : rr_pick
        logic [M_WIDTH-1:0] idx;
        pick = ptr_q;
        for (int i = NM - 1; i >= 0; i--) begin
            idx = ptr_q + M_WIDTH'(i);
            if (M_WR_ADDR_VALID[idx]) pick = idx;
        end
    end

    // Next-state logic: grant in IDLE, wait AW handshake, wait W LAST handshake
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (|M_WR_ADDR_VALID) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (M_WR_ADDR_VALID[grant_q] && S_WR_ADDR_READY)
                    state_d = DATA;
            end
            DATA: begin
                if (M_WR_DATA_VALID[grant_q] && S_WR_DATA_READY &&
                    M_WR_DATA_LAST[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and grant registers
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // AW/W muxing: payload always follows the grant, handshakes gated by state
    always_comb begin
        S_WR_ADDR_ID    = {grant_q, M_WR_ADDR_ID[grant_q*2 +: 2]};
        S_WR_ADDR       = M_WR_ADDR[grant_q*32 +: 32];
        S_WR_ADDR_LEN   = M_WR_ADDR_LEN[grant_q*8 +: 8];
        S_WR_ADDR_BURST = M_WR_ADDR_BURST[grant_q*2 +: 2];
        S_WR_DATA       = M_WR_DATA[grant_q*32 +: 32];
        S_WR_STRB       = M_WR_STRB[grant_q*4 +: 4];
        S_WR_DATA_LAST  = M_WR_DATA_LAST[grant_q];
        S_WR_ADDR_VALID = 1'b0;
        S_WR_DATA_VALID = 1'b0;
        M_WR_ADDR_READY = '0;
        M_WR_DATA_READY = '0;
        if (state_q == ADDR) begin
            S_WR_ADDR_VALID          = M_WR_ADDR_VALID[grant_q];
            M_WR_ADDR_READY[grant_q] = S_WR_ADDR_READY;
        end
        if (state_q == DATA) begin
            S_WR_DATA_VALID          = M_WR_DATA_VALID[grant_q];
            M_WR_DATA_READY[grant_q] = S_WR_DATA_READY;
        end
    end

    // B path: routed by the master index carried in the upper ID bits
    always_comb begin
        bk                  = S_WR_BACK_ID[M_WIDTH+1:2];
        M_WR_BACK_VALID     = '0;
        M_WR_BACK_VALID[bk] = S_WR_BACK_VALID;
        M_WR_BACK_ID        = {NM{S_WR_BACK_ID[1:0]}};
        M_WR_BACK_RESP      = {NM{S_WR_BACK_RESP}};
        S_WR_BACK_READY     = M_WR_BACK_READY[bk];
    end

    assign GRANT = grant_q;
    assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (M_WIDTH=2).
// B-path vector table plus hand-written AW/W burst sequences.
module tb_axi_wr_arbiter;

    localparam int MW = 2;
    localparam int NM = 4;

    logic             BUS_CLK, BUS_RST;
    logic [NM*2-1:0]  M_WR_ADDR_ID;
    logic [NM*32-1:0] M_WR_ADDR;
    logic [NM*8-1:0]  M_WR_ADDR_LEN;
    logic [NM*2-1:0]  M_WR_ADDR_BURST;
    logic [NM-1:0]    M_WR_ADDR_VALID, M_WR_ADDR_READY;
    logic [NM*32-1:0] M_WR_DATA;
    logic [NM*4-1:0]  M_WR_STRB;
    logic [NM-1:0]    M_WR_DATA_LAST, M_WR_DATA_VALID, M_WR_DATA_READY;
    logic [NM*2-1:0]  M_WR_BACK_ID, M_WR_BACK_RESP;
    logic [NM-1:0]    M_WR_BACK_VALID, M_WR_BACK_READY;
    logic [MW+1:0]    S_WR_ADDR_ID;
    logic [31:0]      S_WR_ADDR;
    logic [7:0]       S_WR_ADDR_LEN;
    logic [1:0]       S_WR_ADDR_BURST;
    logic             S_WR_ADDR_VALID, S_WR_ADDR_READY;
    logic [31:0]      S_WR_DATA;
    logic [3:0]       S_WR_STRB;
    logic             S_WR_DATA_LAST, S_WR_DATA_VALID, S_WR_DATA_READY;
    logic [MW+1:0]    S_WR_BACK_ID;
    logic [1:0]       S_WR_BACK_RESP;
    logic             S_WR_BACK_VALID, S_WR_BACK_READY;
    logic [MW-1:0]    GRANT;
    logic             BUSY;

    axi_wr_arbiter #(.M_WIDTH(MW)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .M_WR_ADDR_ID(M_WR_ADDR_ID), .M_WR_ADDR(M_WR_ADDR),
        .M_WR_ADDR_LEN(M_WR_ADDR_LEN), .M_WR_ADDR_BURST(M_WR_ADDR_BURST),
        .M_WR_ADDR_VALID(M_WR_ADDR_VALID), .M_WR_ADDR_READY(M_WR_ADDR_READY),
        .M_WR_DATA(M_WR_DATA), .M_WR_STRB(M_WR_STRB),
        .M_WR_DATA_LAST(M_WR_DATA_LAST), .M_WR_DATA_VALID(M_WR_DATA_VALID),
        .M_WR_DATA_READY(M_WR_DATA_READY),
        .M_WR_BACK_ID(M_WR_BACK_ID), .M_WR_BACK_RESP(M_WR_BACK_RESP),
        .M_WR_BACK_VALID(M_WR_BACK_VALID), .M_WR_BACK_READY(M_WR_BACK_READY),
        .S_WR_ADDR_ID(S_WR_ADDR_ID), .S_WR_ADDR(S_WR_ADDR),
        .S_WR_ADDR_LEN(S_WR_ADDR_LEN), .S_WR_ADDR_BURST(S_WR_ADDR_BURST),
        .S_WR_ADDR_VALID(S_WR_ADDR_VALID), .S_WR_ADDR_READY(S_WR_ADDR_READY),
        .S_WR_DATA(S_WR_DATA), .S_WR_STRB(S_WR_STRB),
        .S_WR_DATA_LAST(S_WR_DATA_LAST), .S_WR_DATA_VALID(S_WR_DATA_VALID),
        .S_WR_DATA_READY(S_WR_DATA_READY),
        .S_WR_BACK_ID(S_WR_BACK_ID), .S_WR_BACK_RESP(S_WR_BACK_RESP),
        .S_WR_BACK_VALID(S_WR_BACK_VALID), .S_WR_BACK_READY(S_WR_BACK_READY),
        .GRANT(GRANT), .BUSY(BUSY)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    typedef struct {
        logic [3:0] sid;
        logic       sval;
        logic [1:0] resp;
        logic [3:0] mready;
        logic [3:0] exp_mvalid;
        logic [1:0] exp_mid;
        logic       exp_sready;
    } bvec_t;

    bvec_t btab[6];
    int    checks = 0;
    int    errors = 0;
    int    hs;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic set_aw(input int m, input logic [1:0] id,
                          input logic [31:0] a, input logic [7:0] len,
                          input logic v);
        M_WR_ADDR_ID[m*2 +: 2]    = id;
        M_WR_ADDR[m*32 +: 32]     = a;
        M_WR_ADDR_LEN[m*8 +: 8]   = len;
        M_WR_ADDR_BURST[m*2 +: 2] = 2'b01;
        M_WR_ADDR_VALID[m]        = v;
    endtask

    task automatic set_w(input int m, input logic [31:0] d,
                         input logic last, input logic v);
        M_WR_DATA[m*32 +: 32] = d;
        M_WR_STRB[m*4 +: 4]   = 4'hF;
        M_WR_DATA_LAST[m]     = last;
        M_WR_DATA_VALID[m]    = v;
    endtask

    initial begin
        btab[0] = '{4'hE, 1'b1, 2'd0, 4'b0000, 4'b1000, 2'd2, 1'b0};
        btab[1] = '{4'hE, 1'b1, 2'd1, 4'b1000, 4'b1000, 2'd2, 1'b1};
        btab[2] = '{4'h1, 1'b1, 2'd2, 4'b0001, 4'b0001, 2'd1, 1'b1};
        btab[3] = '{4'h7, 1'b1, 2'd3, 4'b1101, 4'b0010, 2'd3, 1'b0};
        btab[4] = '{4'hB, 1'b0, 2'd0, 4'b0100, 4'b0000, 2'd3, 1'b1};
        btab[5] = '{4'h8, 1'b1, 2'd2, 4'b1111, 4'b0100, 2'd0, 1'b1};

        BUS_RST = 1'b1;
        M_WR_ADDR_ID = '0; M_WR_ADDR = '0; M_WR_ADDR_LEN = '0;
        M_WR_ADDR_BURST = '0; M_WR_ADDR_VALID = '0;
        M_WR_DATA = '0; M_WR_STRB = '0; M_WR_DATA_LAST = '0;
        M_WR_DATA_VALID = '0; M_WR_BACK_READY = '0;
        S_WR_ADDR_READY = 1'b0; S_WR_DATA_READY = 1'b0;
        S_WR_BACK_ID = '0; S_WR_BACK_RESP = '0; S_WR_BACK_VALID = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_grant", GRANT, 0);
        chk("rst_awvalid", S_WR_ADDR_VALID, 0);
        chk("rst_wvalid", S_WR_DATA_VALID, 0);
        chk("rst_awready", M_WR_ADDR_READY, 0);
        chk("rst_wready", M_WR_DATA_READY, 0);
        BUS_RST = 1'b0;
        tick();

        // B routing table
        for (int i = 0; i < 6; i++) begin
            S_WR_BACK_ID    = btab[i].sid;
            S_WR_BACK_VALID = btab[i].sval;
            S_WR_BACK_RESP  = btab[i].resp;
            M_WR_BACK_READY = btab[i].mready;
            #1;
            chk("b_valid", M_WR_BACK_VALID, btab[i].exp_mvalid);
            chk("b_id", M_WR_BACK_ID, {4{btab[i].exp_mid}});
            chk("b_resp", M_WR_BACK_RESP, {4{btab[i].resp}});
            chk("b_sready", S_WR_BACK_READY, btab[i].exp_sready);
        end
        S_WR_BACK_VALID = 1'b0;
        M_WR_BACK_READY = '0;

        // single request from master 2, W offered before AW
        set_aw(2, 2'd1, 32'h1000, 8'd3, 1'b1);
        set_w(2, 32'hA0, 1'b0, 1'b1);
        S_WR_ADDR_READY = 1'b1;
        S_WR_DATA_READY = 1'b1;
        #1;
        chk("idle_awvalid", S_WR_ADDR_VALID, 0);
        chk("idle_w_held", M_WR_DATA_READY, 0);
        chk("idle_busy", BUSY, 0);
        tick();
        S_WR_BACK_ID    = 4'h5;
        S_WR_BACK_VALID = 1'b1;
        M_WR_BACK_READY = 4'b0010;
        #1;
        chk("aw_valid", S_WR_ADDR_VALID, 1);
        chk("aw_id", S_WR_ADDR_ID, 4'h9);
        chk("aw_addr", S_WR_ADDR, 32'h1000);
        chk("aw_len", S_WR_ADDR_LEN, 3);
        chk("aw_grant", GRANT, 2);
        chk("aw_busy", BUSY, 1);
        chk("aw_mready", M_WR_ADDR_READY, 4'b0100);
        chk("aw_w_held", M_WR_DATA_READY, 0);
        chk("aw_wvalid", S_WR_DATA_VALID, 0);
        chk("aw_b_valid", M_WR_BACK_VALID, 4'b0010);
        chk("aw_b_sready", S_WR_BACK_READY, 1);
        tick();
        S_WR_BACK_VALID = 1'b0;
        M_WR_BACK_READY = '0;
        set_aw(2, 2'd1, 32'h1000, 8'd3, 1'b0);
        for (int b = 0; b < 4; b++) begin
            set_w(2, 32'hA0 + b, b == 3, 1'b1);
            #1;
            chk("d_wvalid", S_WR_DATA_VALID, 1);
            chk("d_wdata", S_WR_DATA, 32'hA0 + b);
            chk("d_wlast", S_WR_DATA_LAST, b == 3);
            chk("d_mready", M_WR_DATA_READY, 4'b0100);
            chk("d_awvalid", S_WR_ADDR_VALID, 0);
            tick();
        end
        set_w(2, 0, 1'b0, 1'b0);
        chk("end_busy", BUSY, 0);

        // pointer now 3: masters 0 and 3 request, 3 wins
        set_aw(0, 2'd0, 32'h50, 8'd0, 1'b1);
        set_aw(3, 2'd0, 32'h60, 8'd0, 1'b1);
        set_w(3, 32'hB3, 1'b1, 1'b1);
        tick();
        chk("ptr3_grant", GRANT, 3);
        set_aw(0, 2'd0, 32'h50, 8'd0, 1'b0);
        tick();
        set_aw(3, 2'd0, 32'h60, 8'd0, 1'b0);
        #1;
        chk("ptr3_wvalid", S_WR_DATA_VALID, 1);
        tick();
        set_w(3, 0, 1'b0, 1'b0);

        // all four request continuously, LEN=0
        for (int i = 0; i < NM; i++) begin
            set_aw(i, 2'(i), 32'h2000 + 16 * i, 8'd0, 1'b1);
            set_w(i, 32'hC0 + i, 1'b1, 1'b1);
        end
        for (int r = 0; r < 5; r++) begin
            #1;
            chk("rr_idle", BUSY, 0);
            tick();
            chk("rr_grant", GRANT, r % 4);
            chk("rr_awid", S_WR_ADDR_ID, 5 * (r % 4));
            chk("rr_awvalid", S_WR_ADDR_VALID, 1);
            tick();
            chk("rr_wdata", S_WR_DATA, 32'hC0 + (r % 4));
            chk("rr_mready", M_WR_DATA_READY, 4'b0001 << (r % 4));
            tick();
        end
        M_WR_ADDR_VALID = '0;
        M_WR_DATA_VALID = '0;

        // 8-beat burst from master 1 with slave W backpressure
        set_aw(1, 2'd2, 32'h3000, 8'd7, 1'b1);
        tick();
        chk("bp_grant_aw", GRANT, 1);
        tick();
        set_aw(1, 2'd2, 32'h3000, 8'd7, 1'b0);
        hs = 0;
        for (int c = 0; c < 40 && hs < 8; c++) begin
            S_WR_DATA_READY = (c % 2 == 0);
            set_w(1, 32'h100 + hs, hs == 7, 1'b1);
            #1;
            chk("bp_busy", BUSY, 1);
            chk("bp_grant", GRANT, 1);
            chk("bp_wdata", S_WR_DATA, 32'h100 + hs);
            chk("bp_mready", M_WR_DATA_READY, (c % 2 == 0) ? 4'b0010 : 4'b0000);
            if (c % 2 == 0) hs++;
            tick();
        end
        chk("bp_done_idle", BUSY, 0);
        set_w(1, 0, 1'b0, 1'b0);
        S_WR_DATA_READY = 1'b1;

        // reset mid-DATA after 2 of 4 beats from master 2
        set_aw(2, 2'd3, 32'h4000, 8'd3, 1'b1);
        tick();
        chk("rd_grant", GRANT, 2);
        tick();
        set_aw(2, 2'd3, 32'h4000, 8'd3, 1'b0);
        for (int b = 0; b < 2; b++) begin
            set_w(2, 32'hD0 + b, 1'b0, 1'b1);
            tick();
        end
        BUS_RST = 1'b1;
        tick();
        chk("rm_busy", BUSY, 0);
        chk("rm_grant", GRANT, 0);
        chk("rm_awvalid", S_WR_ADDR_VALID, 0);
        chk("rm_wvalid", S_WR_DATA_VALID, 0);
        chk("rm_awready", M_WR_ADDR_READY, 0);
        chk("rm_wready", M_WR_DATA_READY, 0);
        BUS_RST = 1'b0;
        set_w(2, 0, 1'b0, 1'b0);
        set_aw(1, 2'd1, 32'h5000, 8'd0, 1'b1);
        set_aw(3, 2'd0, 32'h6000, 8'd0, 1'b1);
        tick();
        chk("rm_new_grant", GRANT, 1);
        chk("rm_new_awid", S_WR_ADDR_ID, 4'h5);
        M_WR_ADDR_VALID = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
